seg_page_sched: RTL

Display page scheduler that shares the single 4-digit seven-segment display between four 16-bit data sources (e.g. PC, ALU result, register read port, memory data). It selects one valid source at a time, rotates pages on a dwell timer or on a debounced push-button, and drives the 16-bit hex value and page index consumed by the display multiplexer. It sits between the CPU debug taps and the seven-segment driver.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_page_sched_if.sv | 24 ++
 rtl/btn_debounce.sv | 44 ++++
 rtl/seg_page_sched.sv | 86 ++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment page scheduler.
package seg_pkg;

  localparam int N_SRC  = 4;
  localparam int DATA_W = 16;
  localparam int PAGE_W = 2;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SHOW = 2'd1;
  localparam state_t ADV  = 2'd2;

  typedef struct packed {
    logic              found;
    logic [PAGE_W-1:0] idx;
  } pick_t;

  // Round-robin pick starting at cur+1 and wrapping through cur itself.
  // Scanning offsets from far to near lets the nearest valid index win.
  function automatic pick_t rr_pick(input logic [PAGE_W-1:0] cur,
                                    input logic [N_SRC-1:0]  valid);
    pick_t             r;
    logic [PAGE_W-1:0] cand;
    r = '0;
    for (int unsigned i = N_SRC; i >= 1; i--) begin
      cand = cur + PAGE_W'(i);
      if (valid[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_page_sched_if.sv
// Source taps, controls and display outputs of the page scheduler.
interface seg_page_sched_if;
  import seg_pkg::*;

  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_valid;
  logic                    btn_next;
  logic                    auto_en;
  logic                    freeze;
  logic [DATA_W-1:0]       disp_x;
  logic [PAGE_W-1:0]       page;
  logic                    blank;

  modport master (
    output src_data, src_valid, btn_next, auto_en, freeze,
    input  disp_x, page, blank
  );

  modport slave (
    input  src_data, src_valid, btn_next, auto_en, freeze,
    output disp_x, page, blank
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button synchronizer, debounce filter and rising-edge pulse generator.
module btn_debounce #(
  parameter int DEB = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic next_pulse
);

  localparam int CNT_W = (DEB > 2) ? $clog2(DEB) : 1;

  logic             s1;
  logic             s2;
  logic             lvl;
  logic             lvl_d;
  logic [CNT_W-1:0] cnt;

  // Level is accepted only after DEB consecutive samples differing from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_d <= lvl;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign next_pulse = lvl & ~lvl_d;

endmodule

// File: rtl/seg_page_sched.sv
// Rotates one of four valid 16-bit sources onto the shared hex display.
module seg_page_sched
  import seg_pkg::*;
#(
  parameter int DWELL = 50_000_000,
  parameter int DEB   = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_page_sched_if.slave   bus
);

  localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;

  logic              next_pulse;
  state_t            state;
  logic [PAGE_W-1:0] page;
  logic [DATA_W-1:0] disp_x;
  logic              blank;
  logic [DW_W-1:0]   dwell;
  logic [DATA_W-1:0] cur_data;
  logic [DATA_W-1:0] pick_data;
  logic              timer_hit;
  logic              advance;
  pick_t             pick;

  btn_debounce #(.DEB(DEB)) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (bus.btn_next),
    .next_pulse (next_pulse)
  );

  // Losing the current source always advances; freeze only masks timer/button.
  always_comb begin
    cur_data  = bus.src_data[page*DATA_W +: DATA_W];
    pick      = rr_pick(page, bus.src_valid);
    pick_data = bus.src_data[pick.idx*DATA_W +: DATA_W];
    timer_hit = bus.auto_en && (dwell == DW_W'(DWELL - 1));
    advance   = !bus.src_valid[page] || (!bus.freeze && (timer_hit || next_pulse));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      page   <= '0;
      disp_x <= '0;
      blank  <= 1'b1;
      dwell  <= '0;
    end else begin
      case (state)
        IDLE: begin
          blank  <= 1'b1;
          disp_x <= '0;
          dwell  <= '0;
          if (|bus.src_valid) state <= ADV;
        end
        SHOW: begin
          if (!bus.freeze) disp_x <= cur_data;
          if (!bus.auto_en)                 dwell <= '0;
          else if (!bus.freeze && !advance) dwell <= dwell + DW_W'(1);
          if (advance) state <= ADV;
        end
        ADV: begin
          dwell <= '0;
          if (pick.found) begin
            page   <= pick.idx;
            disp_x <= pick_data;
            blank  <= 1'b0;
            state  <= SHOW;
          end else begin
            blank  <= 1'b1;
            disp_x <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.disp_x = disp_x;
  assign bus.page   = page;
  assign bus.blank  = blank;

endmodule
